dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 64, number of direct-mapped lines (power of two, 2..1024).
REQ-002 SHALL have parameter BLOCK_BITS, default 256, line size in bits (power of two, 64..1024, at least 2 words).
REQ-003 SHALL have input CLK, 1 bit, the only clock; all state updates on rising edge.
REQ-004 SHALL have input RESET, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have inputs data_address_2DC 32, read_2DC 1, write_2DC 1, data_write_2DC 32, data_write_size_2DC 2 (1..3 bytes, 0 = 4 bytes), flush_2DC 1: CPU request.
REQ-006 SHALL have outputs data_read_fDC 32 (read word), data_valid_fDC 1 (request complete this cycle).
REQ-007 SHALL have outputs data_address_2DM 32 (block-aligned), dBlkRead 1, dBlkWrite 1, block_write_2DM BLOCK_BITS; inputs block_read_fDM BLOCK_BITS, block_read_fDM_valid 1, block_write_fDM_valid 1.

Function
REQ-008 SHALL split address: offset = log2(BLOCK_BITS/8) bits, index = log2(NUM_LINES) bits, tag = remaining upper bits; each line holds valid, dirty, tag, data.
REQ-009 SHALL use states IDLE, WRITEBACK, FILL, FLUSH; IDLE is the reset state.
REQ-010 SHALL, in IDLE, on read hit, drive data_read_fDC with the addressed word combinationally and data_valid_fDC=1 in the same cycle (zero wait).
REQ-011 SHALL, in IDLE, on write hit, assert data_valid_fDC=1 in the same cycle and update the line at the clock edge, setting dirty.
REQ-012 SHALL write N bytes from the least-significant N bytes of data_write_2DC into big-endian byte lanes starting at address[1:0], where byte offset 0 = bits 31:24; bytes past the word boundary are dropped.
REQ-013 SHALL, on miss with a dirty victim, enter WRITEBACK: hold dBlkWrite=1, block_write_2DM = victim data, data_address_2DM = victim tag/index, until block_write_fDM_valid=1 is sampled, then clear dirty and enter FILL.
REQ-014 SHALL, on miss with a clean or invalid victim, enter FILL directly: hold dBlkRead=1 with the requested block address until block_read_fDM_valid=1 is sampled, then install the line (valid=1, dirty=0) and return to IDLE.
REQ-015 SHALL keep data_valid_fDC=0 in WRITEBACK and FILL; the replayed request hits in IDLE the cycle after the fill; total miss latency = handshake cycles + 1.
REQ-016 SHALL never assert dBlkRead and dBlkWrite in the same cycle.
REQ-017 SHALL give priority flush_2DC > write_2DC > read_2DC when several are high in IDLE.
REQ-018 SHALL keep data_valid_fDC=0 and keep the data array unchanged when no request is active.

Reset
REQ-019 SHALL, while RESET=0, immediately force state IDLE, clear all valid and dirty bits, and drive dBlkRead=0, dBlkWrite=0, data_valid_fDC=0, data_read_fDC=0, data_address_2DM=0, block_write_2DM=0; an in-flight block transfer is abandoned.

Configuration
REQ-020 SHALL, with DCACHE_FLUSH_EN defined, on flush_2DC in IDLE, enter FLUSH and walk index 0..NUM_LINES-1, writing back each dirty line via the REQ-013 handshake and invalidating every line, then pulse data_valid_fDC=1 for one cycle and return to IDLE.
REQ-021 SHALL, without DCACHE_FLUSH_EN, exclude the FLUSH state and ignore flush_2DC, which remains a port.

Structure
REQ-022 SHALL place the state enum, the default BLOCK_BITS, and the offset, index and tag width functions in shared package dcache_pkg.
REQ-023 SHALL instantiate one sub-module dcache_line_store holding the tag, valid, dirty and data arrays, with one read port and one write port.

Verification
REQ-024 SHALL cover: read 0x00000040 after reset -> dBlkRead=1 with address 0x00000040; memory returns the block with word 0 = 0xDEADBEEF; the next cycle data_valid_fDC=1, data_read_fDC=0xDEADBEEF.
REQ-025 SHALL cover: write 0x12345678 size 0 to the cached 0x00000044, then read it -> both complete in 1 cycle each with no dBlkRead; the read returns 0x12345678.
REQ-026 SHALL cover: write 0xAB size 1 to 0x00000046 over 0x12345678 -> the read of 0x44 returns 0x1234AB78.
REQ-027 SHALL cover, with NUM_LINES=64: dirty line at 0x40, then read 0x840 -> dBlkWrite with address 0x40 first, then dBlkRead with address 0x840, never overlapping.
REQ-028 SHALL cover: block_read_fDM_valid delayed 5 cycles, with RESET pulsed low in cycle 3 -> dBlkRead drops immediately, and a later read of 0x40 misses again.
REQ-029 SHALL cover, with DCACHE_FLUSH_EN: 2 dirty lines, then flush_2DC -> exactly 2 dBlkWrite handshakes, then one data_valid_fDC pulse, and every subsequent read misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, widths and byte-merge helper for the direct-mapped data cache controller.
// The FLUSH state exists only when DCACHE_FLUSH_EN is defined.
package dcache_pkg;

    localparam int ADDR_W             = 32;
    localparam int WORD_BITS          = 32;
    localparam int DEFAULT_BLOCK_BITS = 256;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
`ifdef DCACHE_FLUSH_EN
        , FLUSH   = 2'd3
`endif
    } state_t;

    function automatic int offset_bits(input int block_bits);
        return $clog2(block_bits / 8);
    endfunction

    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int num_lines, input int block_bits);
        return ADDR_W - offset_bits(block_bits) - index_bits(num_lines);
    endfunction

    // Big-endian lanes: lane 0 is bits 31:24. The first written byte is the most
    // significant of the low N bytes of wdata; bytes past lane 3 are dropped.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane0);
        logic [31:0] w;
        int          n;
        int          k;
        w = old_word;
        n = (size == 2'd0) ? 4 : int'(size);
        for (int l = 0; l < 4; l++) begin
            k = l - int'(lane0);
            if (k >= 0 && k < n) begin
                w[8*(3-l) +: 8] = wdata[8*(n-1-k) +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the data cache: valid, dirty, tag and data arrays with one
// combinational read port and one clocked write port.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int BLOCK_BITS = DEFAULT_BLOCK_BITS,
    parameter int IDX_W      = index_bits(NUM_LINES),
    parameter int TAG_W      = tag_bits(NUM_LINES, BLOCK_BITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data
);

    logic [NUM_LINES-1:0]  valid_bits;
    logic [NUM_LINES-1:0]  dirty_bits;
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [BLOCK_BITS-1:0] data_mem [NUM_LINES];

    assign rd_valid = valid_bits[rd_index];
    assign rd_dirty = dirty_bits[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (we) begin
            valid_bits[wr_index] <= wr_valid;
            dirty_bits[wr_index] <= wr_dirty;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset so they map onto RAM;
    // their contents are never observed while the line's valid bit is clear.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller with zero-wait hits and a
// block write-back/fill handshake. Define DCACHE_FLUSH_EN to enable the flush walk.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int BLOCK_BITS = DEFAULT_BLOCK_BITS
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           data_address_2DC,
    input  logic                  read_2DC,
    input  logic                  write_2DC,
    input  logic [31:0]           data_write_2DC,
    input  logic [1:0]            data_write_size_2DC,
    input  logic                  flush_2DC,
    output logic [31:0]           data_read_fDC,
    output logic                  data_valid_fDC,
    output logic [31:0]           data_address_2DM,
    output logic                  dBlkRead,
    output logic                  dBlkWrite,
    output logic [BLOCK_BITS-1:0] block_write_2DM,
    input  logic [BLOCK_BITS-1:0] block_read_fDM,
    input  logic                  block_read_fDM_valid,
    input  logic                  block_write_fDM_valid
);

    localparam int OFF_W  = offset_bits(BLOCK_BITS);
    localparam int IDX_W  = index_bits(NUM_LINES);
    localparam int TAG_W  = tag_bits(NUM_LINES, BLOCK_BITS);
    localparam int WSEL_W = OFF_W - 2;

    state_t                state;
    logic [ADDR_W-1:0]     fill_addr;
    logic                  flushing;
    logic                  done_pulse;

    logic [IDX_W-1:0]      rd_index;
    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_BITS-1:0] rd_data;
    logic                  we, wr_valid, wr_dirty;
    logic [IDX_W-1:0]      wr_index;
    logic [TAG_W-1:0]      wr_tag;
    logic [BLOCK_BITS-1:0] wr_data;

    logic [IDX_W-1:0]      req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic [WSEL_W-1:0]     word_sel;
    logic [31:0]           rd_word;
    logic                  flush_req, idle_live, hit, do_write, do_read, miss;

`ifdef DCACHE_FLUSH_EN
    logic [IDX_W-1:0]      flush_idx;
    assign flush_req = flush_2DC;
`else
    logic unused_flush;
    assign unused_flush = flush_2DC;
    assign flush_req    = 1'b0;
    assign flushing     = 1'b0;
    assign done_pulse   = 1'b0;
`endif

    assign req_idx  = data_address_2DC[OFF_W +: IDX_W];
    assign req_tag  = data_address_2DC[OFF_W+IDX_W +: TAG_W];
    assign word_sel = data_address_2DC[2 +: WSEL_W];
    assign fill_idx = fill_addr[OFF_W +: IDX_W];
    assign fill_tag = fill_addr[OFF_W+IDX_W +: TAG_W];

    always_comb begin
        rd_index = (state == IDLE) ? req_idx : fill_idx;
`ifdef DCACHE_FLUSH_EN
        if (flushing) rd_index = flush_idx;
`endif
    end

    assign rd_word   = rd_data[WORD_BITS*word_sel +: WORD_BITS];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign idle_live = (state == IDLE) && !done_pulse;
    assign do_write  = idle_live && !flush_req && write_2DC;
    assign do_read   = idle_live && !flush_req && !write_2DC && read_2DC;
    assign miss      = (do_write || do_read) && !hit;

    assign data_valid_fDC = done_pulse || ((do_write || do_read) && hit);
    assign data_read_fDC  = (do_read && hit) ? rd_word : '0;

    dcache_line_store #(
        .NUM_LINES  (NUM_LINES),
        .BLOCK_BITS (BLOCK_BITS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk      (CLK),
        .rst_n    (RESET),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (we),
        .wr_index (wr_index),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    // NOTE: every signal gets a default before the case so this block never infers a latch.
    always_comb begin
        we       = 1'b0;
        wr_index = rd_index;
        wr_valid = rd_valid;
        wr_dirty = 1'b0;
        wr_tag   = rd_tag;
        wr_data  = rd_data;
        case (state)
            IDLE: begin
                if (do_write && hit) begin
                    we       = 1'b1;
                    wr_valid = 1'b1;
                    wr_dirty = 1'b1;
                    wr_data[WORD_BITS*word_sel +: WORD_BITS] =
                        merge_bytes(rd_word, data_write_2DC, data_write_size_2DC,
                                    data_address_2DC[1:0]);
                end
            end
            WRITEBACK: begin
                // A flush write-back also invalidates; a miss write-back only cleans.
                if (block_write_fDM_valid) begin
                    we       = 1'b1;
                    wr_valid = rd_valid && !flushing;
                end
            end
            FILL: begin
                if (block_read_fDM_valid) begin
                    we       = 1'b1;
                    wr_index = fill_idx;
                    wr_valid = 1'b1;
                    wr_tag   = fill_tag;
                    wr_data  = block_read_fDM;
                end
            end
`ifdef DCACHE_FLUSH_EN
            FLUSH: begin
                if (!(rd_valid && rd_dirty)) begin
                    we       = 1'b1;
                    wr_valid = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= IDLE;
            dBlkRead         <= 1'b0;
            dBlkWrite        <= 1'b0;
            data_address_2DM <= '0;
            block_write_2DM  <= '0;
            fill_addr        <= '0;
`ifdef DCACHE_FLUSH_EN
            flushing         <= 1'b0;
            done_pulse       <= 1'b0;
            flush_idx        <= '0;
`endif
        end else begin
`ifdef DCACHE_FLUSH_EN
            done_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef DCACHE_FLUSH_EN
                    if (idle_live && flush_req) begin
                        state     <= FLUSH;
                        flushing  <= 1'b1;
                        flush_idx <= '0;
                    end
`endif
                    if (miss) begin
                        fill_addr <= {data_address_2DC[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        if (rd_valid && rd_dirty) begin
                            state            <= WRITEBACK;
                            dBlkWrite        <= 1'b1;
                            data_address_2DM <= {rd_tag, req_idx, {OFF_W{1'b0}}};
                            block_write_2DM  <= rd_data;
                        end else begin
                            state            <= FILL;
                            dBlkRead         <= 1'b1;
                            data_address_2DM <= {data_address_2DC[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (block_write_fDM_valid) begin
                        dBlkWrite <= 1'b0;
`ifdef DCACHE_FLUSH_EN
                        if (flushing) begin
                            state <= FLUSH;
                        end else
`endif
                        begin
                            state            <= FILL;
                            dBlkRead         <= 1'b1;
                            data_address_2DM <= fill_addr;
                        end
                    end
                end
                FILL: begin
                    if (block_read_fDM_valid) begin
                        dBlkRead <= 1'b0;
                        state    <= IDLE;
                    end
                end
`ifdef DCACHE_FLUSH_EN
                FLUSH: begin
                    if (rd_valid && rd_dirty) begin
                        state            <= WRITEBACK;
                        dBlkWrite        <= 1'b1;
                        data_address_2DM <= {rd_tag, flush_idx, {OFF_W{1'b0}}};
                        block_write_2DM  <= rd_data;
                    end else if (flush_idx == IDX_W'(NUM_LINES - 1)) begin
                        state      <= IDLE;
                        flushing   <= 1'b0;
                        done_pulse <= 1'b1;
                    end else begin
                        flush_idx <= flush_idx + IDX_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl (NUM_LINES=64, BLOCK_BITS=256);
// the flush scenario is exercised when DCACHE_FLUSH_EN is defined.
module tb_dcache_ctrl;

    localparam int BB = 256;

    logic          CLK;
    logic          RESET;
    logic [31:0]   data_address_2DC;
    logic          read_2DC;
    logic          write_2DC;
    logic [31:0]   data_write_2DC;
    logic [1:0]    data_write_size_2DC;
    logic          flush_2DC;
    logic [31:0]   data_read_fDC;
    logic          data_valid_fDC;
    logic [31:0]   data_address_2DM;
    logic          dBlkRead;
    logic          dBlkWrite;
    logic [BB-1:0] block_write_2DM;
    logic [BB-1:0] block_read_fDM;
    logic          block_read_fDM_valid;
    logic          block_write_fDM_valid;

    int compared   = 0;
    int mismatched = 0;

    dcache_ctrl #(.NUM_LINES(64), .BLOCK_BITS(BB)) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .data_address_2DC      (data_address_2DC),
        .read_2DC              (read_2DC),
        .write_2DC             (write_2DC),
        .data_write_2DC        (data_write_2DC),
        .data_write_size_2DC   (data_write_size_2DC),
        .flush_2DC             (flush_2DC),
        .data_read_fDC         (data_read_fDC),
        .data_valid_fDC        (data_valid_fDC),
        .data_address_2DM      (data_address_2DM),
        .dBlkRead              (dBlkRead),
        .dBlkWrite             (dBlkWrite),
        .block_write_2DM       (block_write_2DM),
        .block_read_fDM        (block_read_fDM),
        .block_read_fDM_valid  (block_read_fDM_valid),
        .block_write_fDM_valid (block_write_fDM_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [BB-1:0] observed, input logic [BB-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [BB-1:0] mk_block(input logic [31:0] base, input logic [31:0] w0);
        logic [BB-1:0] b;
        for (int w = 0; w < 8; w++) b[32*w +: 32] = base + 32'(4 * w);
        b[31:0] = w0;
        return b;
    endfunction

    // The two block requests must never be raised together.
    always @(negedge CLK) begin
        if (RESET && (dBlkRead || dBlkWrite)) check("no_overlap", 1'(dBlkRead & dBlkWrite), 1'b0);
    end

    task automatic serve_fill(input string tag, input logic [31:0] exp_addr,
                              input logic [BB-1:0] blk, input int delay);
        int n = 0;
        while (!dBlkRead && n < 20) begin @(negedge CLK); #1; n++; end
        check({tag, "_rd"}, dBlkRead, 1'b1);
        check({tag, "_addr"}, data_address_2DM, exp_addr);
        check({tag, "_nowr"}, dBlkWrite, 1'b0);
        check({tag, "_wait"}, data_valid_fDC, 1'b0);
        repeat (delay) @(negedge CLK);
        block_read_fDM       = blk;
        block_read_fDM_valid = 1'b1;
        @(negedge CLK);
        block_read_fDM_valid = 1'b0;
    endtask

    task automatic serve_wb(input string tag, input logic [31:0] exp_addr, input logic [BB-1:0] exp_blk);
        int n = 0;
        while (!dBlkWrite && n < 20) begin @(negedge CLK); #1; n++; end
        check({tag, "_wr"}, dBlkWrite, 1'b1);
        check({tag, "_addr"}, data_address_2DM, exp_addr);
        check({tag, "_data"}, block_write_2DM, exp_blk);
        check({tag, "_nord"}, dBlkRead, 1'b0);
        block_write_fDM_valid = 1'b1;
        @(negedge CLK);
        block_write_fDM_valid = 1'b0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size);
        read_2DC            = rd;
        write_2DC           = wr;
        data_address_2DC    = addr;
        data_write_2DC      = wdata;
        data_write_size_2DC = size;
    endtask

    initial begin
        logic [BB-1:0] blk40;
        logic [BB-1:0] exp_wb;
        logic [31:0]   wb_addr [4];
        int            n;
        int            wbs;
        int            pulses;

        RESET                 = 1'b0;
        flush_2DC             = 1'b0;
        block_read_fDM        = '0;
        block_read_fDM_valid  = 1'b0;
        block_write_fDM_valid = 1'b0;
        req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        repeat (2) @(negedge CLK);
        #1;
        check("rst_blkrd",  dBlkRead, 1'b0);
        check("rst_blkwr",  dBlkWrite, 1'b0);
        check("rst_valid",  data_valid_fDC, 1'b0);
        check("rst_rdata",  data_read_fDC, 32'h0);
        check("rst_maddr",  data_address_2DM, 32'h0);
        check("rst_mblock", block_write_2DM, '0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Cold read miss of 0x40, then the replayed hit returns word 0.
        blk40 = mk_block(32'h40, 32'hDEADBEEF);
        req(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
        #1 check("miss40_nv", data_valid_fDC, 1'b0);
        serve_fill("fill40", 32'h40, blk40, 0);
        #1;
        check("hit40_valid", data_valid_fDC, 1'b1);
        check("hit40_data",  data_read_fDC, 32'hDEADBEEF);
        check("hit40_nord",  dBlkRead, 1'b0);
        req(1'b0, 1'b0, 32'h40, 32'h0, 2'd0);
        #1 check("idle_nv", data_valid_fDC, 1'b0);

        // Full-word write hit and read-back, each one cycle.
        @(negedge CLK);
        req(1'b0, 1'b1, 32'h44, 32'h12345678, 2'd0);
        #1 check("wr44_valid", data_valid_fDC, 1'b1);
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h44, 32'h0, 2'd0);
        #1;
        check("rd44_valid", data_valid_fDC, 1'b1);
        check("rd44_data",  data_read_fDC, 32'h12345678);
        check("rd44_nord",  dBlkRead, 1'b0);

        // Partial writes in big-endian lanes, including a dropped trailing byte.
        @(negedge CLK);
        req(1'b0, 1'b1, 32'h46, 32'h000000AB, 2'd1);
        #1 check("wr46_valid", data_valid_fDC, 1'b1);
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h44, 32'h0, 2'd0);
        #1 check("rd44_byte", data_read_fDC, 32'h1234AB78);
        @(negedge CLK);
        req(1'b0, 1'b1, 32'h47, 32'h0000C0DE, 2'd2);
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h44, 32'h0, 2'd0);
        #1 check("rd44_clip", data_read_fDC, 32'h1234ABC0);
        @(negedge CLK);
        req(1'b0, 1'b1, 32'h40, 32'h00112233, 2'd3);
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
        #1 check("rd40_3b", data_read_fDC, 32'h112233EF);
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h5C, 32'h0, 2'd0);
        #1 check("rd5c_word7", data_read_fDC, 32'h0000005C);

        // Conflict miss on a dirty line: write-back of 0x40 first, then fill of 0x840.
        exp_wb          = mk_block(32'h40, 32'h112233EF);
        exp_wb[63:32]   = 32'h1234ABC0;
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h840, 32'h0, 2'd0);
        #1 check("miss840_nv", data_valid_fDC, 1'b0);
        serve_wb("wb40", 32'h40, exp_wb);
        #1;
        serve_fill("fill840", 32'h840, mk_block(32'h840, 32'h84084084), 2);
        #1 check("hit840_data", data_read_fDC, 32'h84084084);
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h44, 32'h0, 2'd0);
        #1;
        serve_fill("refill40", 32'h40, exp_wb, 0);
        #1 check("rd44_after_wb", data_read_fDC, 32'h1234ABC0);

        // Reset while a fill is outstanding abandons it and clears all lines.
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h80, 32'h0, 2'd0);
        @(negedge CLK);
        #1 check("fill80_rd", dBlkRead, 1'b1);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        #1;
        check("arst_blkrd", dBlkRead, 1'b0);
        check("arst_maddr", data_address_2DM, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        req(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
        #1 check("post_rst_miss", data_valid_fDC, 1'b0);
        serve_fill("post_rst_fill", 32'h40, mk_block(32'h40, 32'h0BADF00D), 0);
        #1 check("post_rst_data", data_read_fDC, 32'h0BADF00D);

`ifdef DCACHE_FLUSH_EN
        // Two dirty lines, then a flush walk with two write-backs and one done pulse.
        @(negedge CLK);
        req(1'b0, 1'b1, 32'h40, 32'h55555555, 2'd0);
        @(negedge CLK);
        req(1'b0, 1'b1, 32'hC0, 32'h66666666, 2'd0);
        #1;
        serve_fill("fillc0", 32'hC0, mk_block(32'hC0, 32'h0C0C0C0C), 0);
        #1 check("wrc0_valid", data_valid_fDC, 1'b1);
        @(negedge CLK);
        req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        flush_2DC = 1'b1;
        n = 0; wbs = 0; pulses = 0;
        while (pulses == 0 && n < 400) begin
            @(negedge CLK);
            #1;
            n++;
            if (block_write_fDM_valid) begin
                block_write_fDM_valid = 1'b0;
            end else if (dBlkWrite) begin
                if (wbs < 4) wb_addr[wbs] = data_address_2DM;
                wbs++;
                block_write_fDM_valid = 1'b1;
            end
            if (data_valid_fDC) pulses++;
        end
        flush_2DC = 1'b0;
        check("flush_done", 1'(pulses == 1), 1'b1);
        check("flush_wbs", 32'(wbs), 32'd2);
        check("flush_wb0", wb_addr[0], 32'h40);
        check("flush_wb1", wb_addr[1], 32'hC0);
        @(negedge CLK);
        #1 check("flush_single_pulse", data_valid_fDC, 1'b0);
        req(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
        #1 check("flush_miss40", data_valid_fDC, 1'b0);
        serve_fill("flush_fill40", 32'h40, mk_block(32'h40, 32'h40404040), 0);
        #1 check("flush_rd40", data_read_fDC, 32'h40404040);
        @(negedge CLK);
        req(1'b1, 1'b0, 32'hC0, 32'h0, 2'd0);
        #1 check("flush_missc0", data_valid_fDC, 1'b0);
        serve_fill("flush_fillc0", 32'hC0, mk_block(32'hC0, 32'hC0C0C0C0), 0);
        #1 check("flush_rdc0", data_read_fDC, 32'hC0C0C0C0);
`else
        // Flush is not built in: the request is ignored and the read still hits.
        @(negedge CLK);
        flush_2DC = 1'b1;
        req(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
        #1;
        check("noflush_valid", data_valid_fDC, 1'b1);
        check("noflush_data",  data_read_fDC, 32'h0BADF00D);
        @(negedge CLK);
        #1 check("noflush_nowr", dBlkWrite, 1'b0);
        flush_2DC = 1'b0;
`endif

        @(negedge CLK);
        req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
